gshare_predictor_p: RTL and testbench

- Parametrised next-generation gshare direction predictor for the fetch stage; pairs with the BTB hit signal.
- Generalises history length, PHT size, counter width and checkpoint count.
- Adds per-speculative-tag BHR checkpoints with outcome-corrected recovery, an index output for later update, and a PHT init/flush sweep FSM with a ready flag.

---
 rtl/gshare_predictor_p_pkg.sv | 17 +
 rtl/gshare_pht.sv | 29 ++
 rtl/gshare_predictor_p.sv | 172 +++++++++++++++++
 tb/tb_gshare_predictor_p.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gshare_predictor_p_pkg.sv
// Shared defaults and FSM encoding for the gshare direction predictor.
// Imported by the predictor top and its PHT storage.
package gshare_predictor_p_pkg;

    localparam int GSH_ADDR_LEN    = 32;
    localparam int GSH_BHR_LEN     = 10;
    localparam int GSH_PC_LSB      = 2;
    localparam int GSH_CTR_W       = 2;
    localparam int GSH_CTR_INIT    = 1;
    localparam int GSH_SPECTAG_NUM = 5;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } gsh_state_e;

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: flop array of saturating counters.
// Two async read ports (predict, update) and one write port.
module gshare_pht #(
    parameter int IDX_W = 10,
    parameter int CTR_W = 2
) (
    input  logic             clk,
    input  logic [IDX_W-1:0] rd0_idx,
    output logic [CTR_W-1:0] rd0_ctr,
    input  logic [IDX_W-1:0] rd1_idx,
    output logic [CTR_W-1:0] rd1_ctr,
    input  logic             we,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [CTR_W-1:0] wr_ctr
);

    logic [CTR_W-1:0] mem_q [1<<IDX_W];

    assign rd0_ctr = mem_q[rd0_idx];
    assign rd1_ctr = mem_q[rd1_idx];

    // Counter storage; contents are established by the init sweep.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_idx] <= wr_ctr;
        end
    end

endmodule

// File: rtl/gshare_predictor_p.sv
// Parametrised gshare predictor with per-tag history checkpoints
// and a PHT init/flush sweep that gates the predictor via ready.
module gshare_predictor_p
    import gshare_predictor_p_pkg::*;
#(
    parameter int ADDR_LEN    = GSH_ADDR_LEN,
    parameter int BHR_LEN     = GSH_BHR_LEN,
    parameter int PC_LSB      = GSH_PC_LSB,
    parameter int CTR_W       = GSH_CTR_W,
    parameter int CTR_INIT    = GSH_CTR_INIT,
    parameter int SPECTAG_NUM = GSH_SPECTAG_NUM
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_LEN-1:0]    pc,
    input  logic                   hit_bht,
    input  logic                   pred_en,
    input  logic [SPECTAG_NUM-1:0] spectagnow,
    output logic                   predict_cond,
    output logic [BHR_LEN-1:0]     pred_idx,
    output logic [BHR_LEN-1:0]     bhr_master,
    input  logic                   upd_en,
    input  logic [BHR_LEN-1:0]     upd_idx,
    input  logic                   upd_cond,
    input  logic                   prmiss,
    input  logic                   prsuccess,
    input  logic [SPECTAG_NUM-1:0] prtag,
    input  logic                   pr_cond,
    input  logic                   flush_pht,
    output logic                   ready
);

    localparam logic [BHR_LEN-1:0] IDX_ONE  = 1;
    localparam logic [BHR_LEN-1:0] IDX_LAST = '1;
    localparam logic [CTR_W-1:0]   CTR_ONE  = 1;
    localparam logic [CTR_W-1:0]   CTR_MAX  = '1;
    localparam logic [CTR_W-1:0]   INIT_V   = CTR_INIT[CTR_W-1:0];

    gsh_state_e         state_q, state_d;
    logic [BHR_LEN-1:0] init_idx_q, init_idx_d;
    logic [BHR_LEN-1:0] bhr_q, bhr_d;
    logic [BHR_LEN-1:0] ckpt_q [SPECTAG_NUM];
    logic [BHR_LEN-1:0] ckpt_d [SPECTAG_NUM];
    logic [BHR_LEN-1:0] sel_bhr;
    logic [CTR_W-1:0]   pred_ctr, upd_ctr, upd_next;
    logic [BHR_LEN-1:0] wr_idx;
    logic [CTR_W-1:0]   wr_ctr;
    logic               we;
    logic               push;
    logic               unused_ok;

    // prsuccess needs no action here; the tag is freed upstream.
    assign unused_ok = ^{pc, prsuccess};

    assign ready        = (state_q == ST_RUN);
    assign bhr_master   = bhr_q;
    assign pred_idx     = pc[PC_LSB +: BHR_LEN] ^ bhr_q;
    assign predict_cond = ready & hit_bht & pred_ctr[CTR_W-1];
    assign push         = ready & hit_bht & pred_en & ~prmiss;

    gshare_pht #(
        .IDX_W (BHR_LEN),
        .CTR_W (CTR_W)
    ) u_pht (
        .clk     (clk),
        .rd0_idx (pred_idx),
        .rd0_ctr (pred_ctr),
        .rd1_idx (upd_idx),
        .rd1_ctr (upd_ctr),
        .we      (we),
        .wr_idx  (wr_idx),
        .wr_ctr  (wr_ctr)
    );

    // One-hot AND-OR select of the resolving branch's checkpoint.
    always_comb begin
        sel_bhr = '0;
        for (int k = 0; k < SPECTAG_NUM; k++) begin
            if (prtag[k]) begin
                sel_bhr = sel_bhr | ckpt_q[k];
            end
        end
    end

    // Saturating counter step for the resolved branch.
    always_comb begin
        upd_next = upd_ctr;
        if (upd_cond) begin
            if (upd_ctr != CTR_MAX) begin
                upd_next = upd_ctr + CTR_ONE;
            end
        end else if (upd_ctr != '0) begin
            upd_next = upd_ctr - CTR_ONE;
        end
    end

    // History: mispredict recovery beats a same-cycle push.
    always_comb begin
        bhr_d  = bhr_q;
        ckpt_d = ckpt_q;
        if (prmiss) begin
            if ($onehot(prtag)) begin
                bhr_d = {sel_bhr[BHR_LEN-2:0], pr_cond};
            end
        end else if (push) begin
            bhr_d = {bhr_q[BHR_LEN-2:0], predict_cond};
            for (int k = 0; k < SPECTAG_NUM; k++) begin
                if (spectagnow[k]) begin
                    ckpt_d[k] = bhr_q;
                end
            end
        end
    end

    // Sweep FSM and PHT write mux (init has priority over update).
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        we         = 1'b0;
        wr_idx     = upd_idx;
        wr_ctr     = upd_next;
        unique case (state_q)
            ST_INIT: begin
                we     = 1'b1;
                wr_idx = init_idx_q;
                wr_ctr = INIT_V;
                if (flush_pht) begin
                    init_idx_d = '0;
                end else begin
                    init_idx_d = init_idx_q + IDX_ONE;
                    if (init_idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                we = upd_en;
                if (flush_pht) begin
                    state_d    = ST_INIT;
                    init_idx_d = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State, history and checkpoint registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
            bhr_q      <= '0;
            for (int k = 0; k < SPECTAG_NUM; k++) begin
                ckpt_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            bhr_q      <= bhr_d;
            ckpt_q     <= ckpt_d;
        end
    end

    // A mispredict must name exactly one checkpoint.
    a_prtag_onehot: assert property (
        @(posedge clk) disable iff (!reset)
        prmiss |-> $onehot(prtag)
    );

endmodule

// File: tb/tb_gshare_predictor_p.sv
// Self-checking bench for gshare_predictor_p (BHR_LEN=4).
// Directed vector table, sweep/reset sequences, random vs model.
module tb_gshare_predictor_p;

    localparam int BL = 4;
    localparam int NT = 5;
    localparam int NE = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [31:0]   pc;
    logic          hit_bht, pred_en;
    logic [NT-1:0] spectagnow;
    logic          predict_cond;
    logic [BL-1:0] pred_idx, bhr_master;
    logic          upd_en;
    logic [BL-1:0] upd_idx;
    logic          upd_cond;
    logic          prmiss, prsuccess;
    logic [NT-1:0] prtag;
    logic          pr_cond, flush_pht, ready;

    always #5 clk = ~clk;

    gshare_predictor_p #(
        .ADDR_LEN    (32),
        .BHR_LEN     (BL),
        .PC_LSB      (2),
        .CTR_W       (2),
        .CTR_INIT    (1),
        .SPECTAG_NUM (NT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pc           (pc),
        .hit_bht      (hit_bht),
        .pred_en      (pred_en),
        .spectagnow   (spectagnow),
        .predict_cond (predict_cond),
        .pred_idx     (pred_idx),
        .bhr_master   (bhr_master),
        .upd_en       (upd_en),
        .upd_idx      (upd_idx),
        .upd_cond     (upd_cond),
        .prmiss       (prmiss),
        .prsuccess    (prsuccess),
        .prtag        (prtag),
        .pr_cond      (pr_cond),
        .flush_pht    (flush_pht),
        .ready        (ready)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: counters, history, checkpoints, sweep cycles left.
    int m_pht[NE];
    int m_bhr;
    int m_ck[NT];
    int m_left;

    typedef struct {
        logic [31:0]   pc;
        logic          hit;
        logic          pen;
        logic [NT-1:0] st;
        logic          ue;
        logic [BL-1:0] ui;
        logic          uc;
        logic          pm;
        logic [NT-1:0] pt;
        logic          prc;
        logic          fl;
        logic          e_rdy;
        logic [BL-1:0] e_bhr;
        logic [BL-1:0] e_idx;
        logic          e_pred;
    } vec_t;

    vec_t vt[12];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int exp_idx();
        return int'((pc >> 2) & 32'd15) ^ m_bhr;
    endfunction

    function automatic int exp_pred();
        if (m_left != 0 || !hit_bht) return 0;
        return (m_pht[exp_idx()] >= 2) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_bhr  = 0;
        m_left = NE;
        for (int k = 0; k < NT; k++) m_ck[k] = 0;
    endtask

    // Apply one clock edge worth of architectural effects.
    task automatic model_step();
        int p;
        int old;
        p   = exp_pred();
        old = m_bhr;
        if (prmiss) begin
            if ($onehot(prtag)) begin
                for (int k = 0; k < NT; k++)
                    if (prtag[k]) m_bhr = ((m_ck[k] << 1) | int'(pr_cond)) & 15;
            end
        end else if (m_left == 0 && hit_bht && pred_en) begin
            for (int k = 0; k < NT; k++)
                if (spectagnow[k]) m_ck[k] = old;
            m_bhr = ((old << 1) | p) & 15;
        end
        if (m_left == 0 && upd_en) begin
            if (upd_cond) begin
                if (m_pht[upd_idx] < 3) m_pht[upd_idx]++;
            end else begin
                if (m_pht[upd_idx] > 0) m_pht[upd_idx]--;
            end
        end
        if (flush_pht) begin
            m_left = NE;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0)
                for (int i = 0; i < NE; i++) m_pht[i] = 1;
        end
    endtask

    task automatic check_model();
        chk("m_ready", int'(ready), (m_left == 0) ? 1 : 0);
        chk("m_bhr", int'(bhr_master), m_bhr);
        chk("m_idx", int'(pred_idx), exp_idx());
        chk("m_pred", int'(predict_cond), exp_pred());
    endtask

    // Inputs are set at posedge+1; check at +2, then cross one edge.
    task automatic step();
        #1;
        check_model();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pc         = '0;
        hit_bht    = 1'b0;
        pred_en    = 1'b0;
        spectagnow = '0;
        upd_en     = 1'b0;
        upd_idx    = '0;
        upd_cond   = 1'b0;
        prmiss     = 1'b0;
        prsuccess  = 1'b0;
        prtag      = 5'b00001;
        pr_cond    = 1'b0;
        flush_pht  = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        #2;
        chk("rst_ready", int'(ready), 0);
        chk("rst_bhr", int'(bhr_master), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        //        pc     hit pen st        ue ui uc pm pt        prc fl  rdy bhr idx pred
        vt[0]  = '{32'h00, 0, 0, 5'b00000, 1, 5, 1, 0, 5'b00001, 0, 0, 1, 0, 0, 0};
        vt[1]  = '{32'h00, 0, 0, 5'b00000, 1, 5, 1, 0, 5'b00001, 0, 0, 1, 0, 0, 0};
        vt[2]  = '{32'h00, 0, 0, 5'b00000, 1, 5, 1, 0, 5'b00001, 0, 0, 1, 0, 0, 0};
        vt[3]  = '{32'h14, 1, 0, 5'b00000, 0, 0, 0, 0, 5'b00001, 0, 0, 1, 0, 5, 1};
        vt[4]  = '{32'h14, 1, 1, 5'b00000, 0, 0, 0, 0, 5'b00001, 0, 0, 1, 0, 5, 1};
        vt[5]  = '{32'h10, 1, 1, 5'b00000, 0, 0, 0, 0, 5'b00001, 0, 0, 1, 1, 5, 1};
        vt[6]  = '{32'h18, 1, 1, 5'b00100, 0, 0, 0, 0, 5'b00001, 0, 0, 1, 3, 5, 1};
        vt[7]  = '{32'h14, 1, 1, 5'b00001, 0, 0, 0, 1, 5'b00100, 0, 0, 1, 7, 2, 0};
        vt[8]  = '{32'h14, 1, 0, 5'b00000, 1, 3, 1, 0, 5'b00001, 0, 0, 1, 6, 3, 0};
        vt[9]  = '{32'h14, 1, 0, 5'b00000, 0, 0, 0, 0, 5'b00001, 0, 0, 1, 6, 3, 1};
        vt[10] = '{32'h00, 0, 0, 5'b00000, 0, 0, 0, 0, 5'b00001, 0, 1, 1, 6, 6, 0};
        vt[11] = '{32'h14, 1, 0, 5'b00000, 0, 0, 0, 0, 5'b00001, 0, 0, 0, 6, 3, 0};

        do_reset();

        // Initial sweep: 16 cycles not ready, no prediction.
        for (int i = 0; i < NE; i++) begin
            hit_bht = 1'b1;
            pc      = $urandom;
            #1;
            chk("init_ready", int'(ready), 0);
            chk("init_pred", int'(predict_cond), 0);
            step();
        end
        idle();
        #1;
        chk("init_done", int'(ready), 1);

        // Directed vector table.
        for (int i = 0; i < 12; i++) begin
            pc         = vt[i].pc;
            hit_bht    = vt[i].hit;
            pred_en    = vt[i].pen;
            spectagnow = vt[i].st;
            upd_en     = vt[i].ue;
            upd_idx    = vt[i].ui;
            upd_cond   = vt[i].uc;
            prmiss     = vt[i].pm;
            prtag      = vt[i].pt;
            pr_cond    = vt[i].prc;
            flush_pht  = vt[i].fl;
            #1;
            chk($sformatf("vec%0d_ready", i), int'(ready), int'(vt[i].e_rdy));
            chk($sformatf("vec%0d_bhr", i), int'(bhr_master), int'(vt[i].e_bhr));
            chk($sformatf("vec%0d_idx", i), int'(pred_idx), int'(vt[i].e_idx));
            chk($sformatf("vec%0d_pred", i), int'(predict_cond), int'(vt[i].e_pred));
            step();
        end

        // Rest of the flush sweep, then trained entries are back to 1.
        for (int i = 0; i < NE - 1; i++) begin
            idle();
            hit_bht = 1'b1;
            pc      = 32'h14;
            #1;
            chk("flush_busy", int'(ready), 0);
            step();
        end
        idle();
        hit_bht = 1'b1;
        pc      = 32'h0C;
        #1;
        chk("flush_ready", int'(ready), 1);
        chk("flush_idx5", int'(predict_cond), 0);
        pc = 32'h14;
        #1;
        chk("flush_idx3", int'(predict_cond), 0);
        step();

        // Reset mid-sweep restarts the full 16-cycle sweep.
        idle();
        flush_pht = 1'b1;
        step();
        idle();
        for (int i = 0; i < 5; i++) step();
        do_reset();
        for (int i = 0; i < NE; i++) begin
            #1;
            chk("resweep_busy", int'(ready), 0);
            step();
        end
        #1;
        chk("resweep_done", int'(ready), 1);

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            int r;
            pc         = $urandom;
            hit_bht    = ($urandom_range(0, 3) != 0);
            pred_en    = 1'($urandom_range(0, 1));
            spectagnow = ($urandom_range(0, 3) == 0) ? 5'b0
                       : 5'(1 << $urandom_range(0, NT - 1));
            upd_en     = 1'($urandom_range(0, 1));
            upd_idx    = 4'($urandom_range(0, NE - 1));
            upd_cond   = 1'($urandom_range(0, 1));
            r          = $urandom_range(0, 7);
            prmiss     = (r == 0);
            prsuccess  = (r == 1);
            prtag      = 5'(1 << $urandom_range(0, NT - 1));
            pr_cond    = 1'($urandom_range(0, 1));
            flush_pht  = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
